pic_decode_seq: RTL and testbench

Parametrised, registered successor to the single-phase instruction decoder for the PIC-style core. It generates the four Q-phases internally from one clock and latches each fetched instruction into an instruction register. Decode outputs are registered for a full instruction cycle. The block adds behaviour the old decoder lacked: skip instructions (DECFSZ/INCFSZ/BTFSC/BTFSS), GOTO/CALL flush, stall, and illegal-opcode flagging. It sits between program memory/PC and the ALU mux, register file and W register.

---
 rtl/pic_pkg.sv | 81 ++++++++
 rtl/pic_decode_seq_if.sv | 39 +++
 rtl/q_phase_gen.sv | 35 +++
 rtl/pic_decode_seq.sv | 130 +++++++++++++
 tb/tb_pic_decode_seq.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/pic_pkg.sv
// Shared types and constants for the PIC-style decode sequencer.
package pic_pkg;

    localparam int unsigned KW   = 8;
    localparam int unsigned AOPW = 4;

    typedef enum logic [1:0] {
        CLS_BYTE   = 2'b00,
        CLS_BIT    = 2'b01,
        CLS_BRANCH = 2'b10,
        CLS_LIT    = 2'b11
    } cls_e;

    typedef enum logic [1:0] {
        Q1 = 2'd0,
        Q2 = 2'd1,
        Q3 = 2'd2,
        Q4 = 2'd3
    } phase_e;

    typedef enum logic [1:0] {
        SKIP_NONE = 2'd0,
        SKIP_ZERO = 2'd1,
        SKIP_BCLR = 2'd2,
        SKIP_BSET = 2'd3
    } skip_e;

    localparam logic [AOPW-1:0] ALU_MOVF  = 4'd0;
    localparam logic [AOPW-1:0] ALU_MOVWF = 4'd1;
    localparam logic [AOPW-1:0] ALU_ADD   = 4'd2;
    localparam logic [AOPW-1:0] ALU_SUB   = 4'd3;
    localparam logic [AOPW-1:0] ALU_AND   = 4'd4;
    localparam logic [AOPW-1:0] ALU_INC   = 4'd5;
    localparam logic [AOPW-1:0] ALU_DEC   = 4'd6;
    localparam logic [AOPW-1:0] ALU_XOR   = 4'd7;
    localparam logic [AOPW-1:0] ALU_RLF   = 4'd8;
    localparam logic [AOPW-1:0] ALU_CLR   = 4'd9;
    localparam logic [AOPW-1:0] ALU_IOR   = 4'd10;
    localparam logic [AOPW-1:0] ALU_SWAP  = 4'd11;
    localparam logic [AOPW-1:0] ALU_COM   = 4'd12;
    localparam logic [AOPW-1:0] ALU_BSF   = 4'd13;
    localparam logic [AOPW-1:0] ALU_BCF   = 4'd14;
    localparam logic [AOPW-1:0] ALU_RRF   = 4'd15;

    // Control decoded once per instruction and held for its whole cycle.
    typedef struct packed {
        logic [AOPW-1:0] alu_op;
        logic            d;
        logic            switch_a_m;
        logic            act_ram;
        logic            read_direction;
        logic            illegal;
        logic            writes;
        logic            is_branch;
        skip_e           skip;
    } dec_t;

    function automatic logic [AOPW-1:0] byte_alu_op(input logic [3:0] op);
        logic [AOPW-1:0] r;
        case (op)
            4'b0000: r = ALU_MOVWF;
            4'b0001: r = ALU_CLR;
            4'b0010: r = ALU_SUB;
            4'b0011: r = ALU_DEC;
            4'b0100: r = ALU_IOR;
            4'b0101: r = ALU_AND;
            4'b0110: r = ALU_XOR;
            4'b0111: r = ALU_ADD;
            4'b1000: r = ALU_MOVF;
            4'b1001: r = ALU_COM;
            4'b1010: r = ALU_INC;
            4'b1011: r = ALU_DEC;
            4'b1100: r = ALU_RRF;
            4'b1101: r = ALU_RLF;
            4'b1110: r = ALU_SWAP;
            default: r = ALU_INC;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/pic_decode_seq_if.sv
// Core-side bundle of the decode sequencer: fetch/ALU status in, decode and strobes out.
interface pic_decode_seq_if #(
    parameter int unsigned FAW = 5
);
    localparam int unsigned IW = FAW + 7;

    logic            stall;
    logic [IW-1:0]   inst_in;
    logic            alu_zero;
    logic            f_bit;
    logic [1:0]      phase;
    logic [3:0]      alu_op;
    logic            d;
    logic            switch_a_m;
    logic            act_ram;
    logic            read_direction;
    logic [2:0]      bit_number;
    logic [FAW-1:0]  f_addr;
    logic [7:0]      literal;
    logic [IW-4:0]   pc_target;
    logic            write_en;
    logic            pc_inc;
    logic            pc_load;
    logic            squash;
    logic            illegal;

    modport master (
        output stall, inst_in, alu_zero, f_bit,
        input  phase, alu_op, d, switch_a_m, act_ram, read_direction, bit_number,
               f_addr, literal, pc_target, write_en, pc_inc, pc_load, squash, illegal
    );

    modport slave (
        input  stall, inst_in, alu_zero, f_bit,
        output phase, alu_op, d, switch_a_m, act_ram, read_direction, bit_number,
               f_addr, literal, pc_target, write_en, pc_inc, pc_load, squash, illegal
    );

endinterface

// File: rtl/q_phase_gen.sv
// Four-phase Q1..Q4 sequencer; holds while stalled, reset returns to Q1.
module q_phase_gen
    import pic_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   stall,
    output phase_e phase
);

    phase_e state_q;
    phase_e state_d;

    always_ff @(posedge clk) begin
        if (rst) state_q <= Q1;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (!stall) begin
            unique case (state_q)
                Q1: state_d = Q2;
                Q2: state_d = Q3;
                Q3: state_d = Q4;
                Q4: state_d = Q1;
            endcase
        end
    end

    always_comb begin
        phase = state_q;
    end

endmodule

// File: rtl/pic_decode_seq.sv
// Registered instruction decoder with internal Q-phases, skip/branch squash,
// stall and illegal-opcode flagging.
module pic_decode_seq
    import pic_pkg::*;
#(
    parameter int unsigned FAW = 5
) (
    input logic clk,
    input logic rst,
    pic_decode_seq_if.slave bus
);

    localparam int unsigned IW = FAW + 7;

    phase_e         phase;
    dec_t           dec_c;
    dec_t           dec_q;
    logic [IW-4:0]  ir;            // operand bits of the IR; opcode bits are held decoded in dec_q
    logic           squash;
    logic           skip_pending;
    logic           lit_rsvd_c;
    logic           skip_hit_c;
    logic           live_c;
    logic           branch_go_c;

    q_phase_gen u_phase (
        .clk   (clk),
        .rst   (rst),
        .stall (bus.stall),
        .phase (phase)
    );

    // Literal class reserves every bit between the select field and K.
    assign lit_rsvd_c = |(inst_in_lo() >> KW);

    function automatic logic [IW-5:0] inst_in_lo();
        return bus.inst_in[IW-5:0];
    endfunction

    always_comb begin
        dec_c = '0;
        unique case (cls_e'(bus.inst_in[IW-1:IW-2]))
            CLS_BYTE: begin
                if (bus.inst_in != '0) begin
                    dec_c.alu_op     = byte_alu_op(bus.inst_in[IW-3:IW-6]);
                    dec_c.d          = bus.inst_in[IW-7];
                    dec_c.switch_a_m = 1'b1;
                    dec_c.act_ram    = 1'b1;
                    dec_c.writes     = 1'b1;
                    if (bus.inst_in[IW-3:IW-6] == 4'b1011 || bus.inst_in[IW-3:IW-6] == 4'b1111)
                        dec_c.skip = SKIP_ZERO;
                end
            end
            CLS_BIT: begin
                dec_c.switch_a_m = 1'b1;
                dec_c.act_ram    = 1'b1;
                unique case (bus.inst_in[IW-3:IW-4])
                    2'b00: begin dec_c.alu_op = ALU_BCF; dec_c.d = 1'b1; dec_c.writes = 1'b1; end
                    2'b01: begin dec_c.alu_op = ALU_BSF; dec_c.d = 1'b1; dec_c.writes = 1'b1; end
                    2'b10: dec_c.skip = SKIP_BCLR;
                    2'b11: dec_c.skip = SKIP_BSET;
                endcase
            end
            CLS_LIT: begin
                unique case (bus.inst_in[IW-3:IW-4])
                    2'b00: dec_c.alu_op = ALU_MOVF;
                    2'b01: dec_c.alu_op = ALU_IOR;
                    2'b10: dec_c.alu_op = ALU_AND;
                    2'b11: dec_c.alu_op = ALU_XOR;
                endcase
                dec_c.illegal = lit_rsvd_c;
                dec_c.writes  = ~lit_rsvd_c;
            end
            CLS_BRANCH: begin
                dec_c.read_direction = 1'b1;
                dec_c.is_branch      = 1'b1;
            end
        endcase
    end

    always_comb begin
        skip_hit_c = 1'b0;
        case (dec_q.skip)
            SKIP_ZERO: skip_hit_c = bus.alu_zero;
            SKIP_BCLR: skip_hit_c = ~bus.f_bit;
            SKIP_BSET: skip_hit_c = bus.f_bit;
            default:   skip_hit_c = 1'b0;
        endcase
    end

    // A squashed instruction can neither arm a skip nor redirect, so squashes never chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            ir           <= '0;
            dec_q        <= '0;
            squash       <= 1'b1;
            skip_pending <= 1'b0;
        end else if (!bus.stall) begin
            if (phase == Q3 && !squash && skip_hit_c)
                skip_pending <= 1'b1;
            if (phase == Q4) begin
                ir           <= bus.inst_in[IW-4:0];
                dec_q        <= dec_c;
                squash       <= skip_pending | (dec_q.is_branch & ~squash);
                skip_pending <= 1'b0;
            end
        end
    end

    assign live_c      = ~rst & ~bus.stall;
    assign branch_go_c = dec_q.is_branch & ~squash;

    assign bus.write_en = live_c & (phase == Q3) & ~squash & dec_q.writes;
    assign bus.pc_inc   = live_c & (phase == Q4) & ~branch_go_c;
    assign bus.pc_load  = live_c & (phase == Q4) & branch_go_c;

    assign bus.phase          = phase;
    assign bus.alu_op         = dec_q.alu_op;
    assign bus.d              = dec_q.d;
    assign bus.switch_a_m     = dec_q.switch_a_m;
    assign bus.act_ram        = dec_q.act_ram;
    assign bus.read_direction = dec_q.read_direction;
    assign bus.illegal        = dec_q.illegal;
    assign bus.squash         = squash;
    assign bus.bit_number     = ir[IW-5:IW-7];
    assign bus.f_addr         = ir[FAW-1:0];
    assign bus.literal        = ir[KW-1:0];
    assign bus.pc_target      = ir;

endmodule

// File: tb/tb_pic_decode_seq.sv
// Directed plus randomized bench for pic_decode_seq against an instruction-level model.
module tb_pic_decode_seq;

    localparam int unsigned FAW = 5;
    localparam int unsigned IW  = FAW + 7;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pic_decode_seq_if #(.FAW(FAW)) bus ();
    pic_decode_seq #(.FAW(FAW)) dut (.clk(clk), .rst(rst), .bus(bus));

    int total = 0;
    int bad   = 0;

    // Model: instruction in execution, its squash flag, a pending skip, and the phase.
    int              m_phase;
    logic [IW-1:0]   m_ir;
    bit              m_squash;
    bit              m_skip;

    typedef struct {
        int alu;
        bit d, sw, act, rd, ill, wr, br;
        int skip;   // 0 none, 1 on alu_zero, 2 on f_bit clear, 3 on f_bit set
    } exp_t;

    function automatic exp_t expect_dec(logic [IW-1:0] i);
        int   tab [16] = '{1, 9, 3, 6, 10, 4, 7, 2, 0, 12, 5, 6, 15, 8, 11, 5};
        int   lit [4]  = '{0, 10, 4, 7};
        exp_t e        = '{default: 0};
        int   cls      = int'(i[IW-1:IW-2]);
        int   op       = int'(i[IW-3:IW-6]);
        int   sel      = int'(i[IW-3:IW-4]);
        if (i == '0) return e;
        if (cls == 0) begin
            e.alu = tab[op]; e.d = i[IW-7]; e.sw = 1; e.act = 1; e.wr = 1;
            e.skip = (op == 11 || op == 15) ? 1 : 0;
        end else if (cls == 1) begin
            e.sw = 1; e.act = 1;
            if (sel < 2) begin
                e.alu = (sel == 0) ? 14 : 13; e.d = 1; e.wr = 1;
            end else begin
                e.skip = sel;
            end
        end else if (cls == 3) begin
            e.alu = lit[sel];
            for (int b = 8; b <= int'(IW) - 5; b++) if (i[b]) e.ill = 1;
            e.wr = !e.ill;
        end else begin
            e.rd = 1; e.br = 1;
        end
        return e;
    endfunction

    function automatic bit cond(exp_t e, bit az, bit fb);
        return (e.skip == 1 && az) || (e.skip == 2 && !fb) || (e.skip == 3 && fb);
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // One clock: drive inputs, check this cycle's outputs, then advance the model past the edge.
    task automatic step(bit r, bit st, logic [IW-1:0] ii, bit az, bit fb);
        exp_t e    = expect_dec(m_ir);
        bit   live = !r && !st;
        rst = r; bus.stall = st; bus.inst_in = ii; bus.alu_zero = az; bus.f_bit = fb;
        #1;
        chk("phase",    32'(bus.phase),    32'(m_phase));
        chk("squash",   32'(bus.squash),   32'(m_squash));
        chk("write_en", 32'(bus.write_en), 32'(live && m_phase == 2 && !m_squash && e.wr));
        chk("pc_inc",   32'(bus.pc_inc),   32'(live && m_phase == 3 && !(e.br && !m_squash)));
        chk("pc_load",  32'(bus.pc_load),  32'(live && m_phase == 3 && e.br && !m_squash));
        if (m_phase == 0) begin
            chk("alu_op",         32'(bus.alu_op),         32'(e.alu));
            chk("d",              32'(bus.d),              32'(e.d));
            chk("switch_a_m",     32'(bus.switch_a_m),     32'(e.sw));
            chk("act_ram",        32'(bus.act_ram),        32'(e.act));
            chk("read_direction", 32'(bus.read_direction), 32'(e.rd));
            chk("illegal",        32'(bus.illegal),        32'(e.ill));
            chk("f_addr",         32'(bus.f_addr),         32'(m_ir[FAW-1:0]));
            chk("literal",        32'(bus.literal),        32'(m_ir[7:0]));
            chk("bit_number",     32'(bus.bit_number),     32'(m_ir[IW-5:IW-7]));
            chk("pc_target",      32'(bus.pc_target),      32'(m_ir[IW-4:0]));
        end
        if (r) begin
            m_phase = 0; m_ir = '0; m_squash = 1; m_skip = 0;
        end else if (!st) begin
            if (m_phase == 2 && !m_squash && cond(e, az, fb)) m_skip = 1;
            if (m_phase == 3) begin
                m_squash = m_skip || (e.br && !m_squash);
                m_skip   = 0;
                m_ir     = ii;
            end
            m_phase = (m_phase + 1) % 4;
        end
        @(negedge clk);
    endtask

    // Executes the current instruction for Q1..Q4 and fetches nxt; optional stall burst before phase sp.
    task automatic slot(logic [IW-1:0] nxt, bit az, bit fb, int sp, int sl);
        logic [IW-1:0] ii;
        bit a, f;
        for (int p = 0; p < 4; p++) begin
            if (p == sp) repeat (sl) step(0, 1, IW'($urandom), 1'($urandom), 1'($urandom));
            ii = (p == 3) ? nxt : IW'($urandom);
            a  = (p == 2) ? az  : 1'($urandom);
            f  = (p == 2) ? fb  : 1'($urandom);
            step(0, 0, ii, a, f);
        end
    endtask

    initial begin
        rst = 1'b1; bus.stall = 1'b0; bus.inst_in = '0; bus.alu_zero = 1'b0; bus.f_bit = 1'b0;
        repeat (2) @(negedge clk);
        m_phase = 0; m_ir = '0; m_squash = 1; m_skip = 0;

        slot(12'h1EA, 0, 0, -1, 0);   // reset NOP, fetch ADDWF
        slot(12'h2E3, 0, 0, -1, 0);   // ADDWF writes
        slot(12'h1EA, 1, 0, -1, 0);   // DECFSZ, result zero
        slot(12'h2E3, 0, 0, -1, 0);   // follower squashed
        slot(12'h1EA, 0, 0, -1, 0);   // DECFSZ, nonzero
        slot(12'h766, 0, 0, -1, 0);   // follower writes
        slot(12'h1EA, 0, 1, -1, 0);   // BTFSS bit 3 set
        slot(12'hA05, 0, 0, -1, 0);   // follower squashed
        slot(12'h1EA, 0, 0, -1, 0);   // GOTO 0x05
        slot(12'h766, 0, 0, -1, 0);   // branch shadow squashed
        slot(12'hA05, 0, 1, -1, 0);   // BTFSS skips the GOTO
        slot(12'h1EA, 0, 0, -1, 0);   // squashed GOTO: no load
        slot(12'hC55, 0, 0, -1, 0);   // follower runs normally
        slot(12'hF00, 0, 0, 1, 3);    // MOVLW with stall held in Q2
        slot(12'h000, 0, 0, -1, 0);   // XORLW 0
        slot(12'h000, 0, 0, 2, 2);    // stall inside Q3

        for (int n = 0; n < 60; n++) begin
            int sp;
            sp = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 3)) : -1;
            slot(IW'($urandom), 1'($urandom), 1'($urandom), sp, int'($urandom_range(1, 3)));
        end

        slot(12'h000, 0, 0, -1, 0);
        slot(12'h1EA, 0, 0, -1, 0);
        step(0, 0, IW'($urandom), 0, 0);
        step(0, 0, IW'($urandom), 0, 0);
        step(1, 1, IW'($urandom), 0, 0);   // reset in Q3 of ADDWF, with stall also high
        slot(12'h1EA, 0, 0, -1, 0);
        slot(12'h000, 0, 0, -1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
